// File: rtl/irq_timer_ctrl.sv
// Memory-mapped machine timer plus edge-latched external interrupt
// pending/enable/claim unit driving the CPU eip/eip_istimer request.
module irq_timer_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'he0000000,
   parameter int unsigned NSRC      = 4,
   parameter int unsigned DIV       = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     a,
   input  logic [31:0]     d,
   input  logic            we,
   input  logic            rd,
   output logic [31:0]     spo,
   output logic            ready,
   input  logic [NSRC-1:0] src,
   output logic            eip,
   output logic            eip_istimer,
   input  logic            eip_reply
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned CW = 5;
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_PENDING  = 3'd4;
   localparam logic [2:0] OFF_ENABLE   = 3'd5;
   localparam logic [2:0] OFF_CLAIM    = 3'd6;
   localparam logic [2:0] OFF_STATUS   = 3'd7;

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   logic            sel;
   logic            wr_en;
   logic            rd_en;
   logic [2:0]      off;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic [PW-1:0]   pre;
   logic            tick;
   logic [63:0]     mtime;
   logic [63:0]     mtime_inc;
   logic [63:0]     mtimecmp;
   logic [NSRC-1:0] sync1;
   logic [NSRC-1:0] sync2;
   logic [NSRC-1:0] sync3;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] pend_en;
   logic [NSRC-1:0] en;
   logic            timer_en;
   logic [CW-1:0]   claim;
   logic            busy;
   logic            timer_pend;
   logic            ext_req;
   logic            do_claim;
   logic            found;
   logic [CW-1:0]   claim_id;
   logic [NSRC-1:0] ack_mask;
   logic [NSRC-1:0] clr_mask;
   logic            unused_addr_lsbs;

   assign unused_addr_lsbs = ^a[1:0];

   // Bus decode; the slave stalls the CPU for exactly the strobe cycle
   assign sel   = (a[31:5] == BASE_ADDR[31:5]);
   assign wr_en = sel & we;
   assign rd_en = sel & rd;
   assign off   = a[4:2];
   assign wdata = bswap(d);
   assign ready = ~(wr_en | rd_en);

   assign tick      = (pre == PRE_MAX);
   assign mtime_inc = mtime + 64'(tick);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PW'(1);
      end
   end

   // A write to one half wins over the increment; the carry still reaches the other half
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime    <= '0;
         mtimecmp <= '1;
      end else begin
         mtime[31:0]  <= (wr_en && off == OFF_MTIME_LO) ? wdata : mtime_inc[31:0];
         mtime[63:32] <= (wr_en && off == OFF_MTIME_HI) ? wdata : mtime_inc[63:32];
         if (wr_en && off == OFF_CMP_LO) mtimecmp[31:0]  <= wdata;
         if (wr_en && off == OFF_CMP_HI) mtimecmp[63:32] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= src;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise       = sync2 & ~sync3;
   assign pend_en    = pending & en;
   assign timer_pend = timer_en & (mtime >= mtimecmp);
   assign ext_req    = (|pend_en) & ~busy;
   assign eip        = timer_pend | ext_req;
   assign eip_istimer = timer_pend;
   assign do_claim   = eip_reply & ext_req & ~timer_pend;

   // Lowest enabled pending source gets claimed first
   always_comb begin
      found    = 1'b0;
      claim_id = '0;
      ack_mask = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (pend_en[i] && !found) begin
            found       = 1'b1;
            claim_id    = CW'(i + 1);
            ack_mask[i] = 1'b1;
         end
      end
   end

   always_comb begin
      clr_mask = '0;
      if (wr_en && off == OFF_PENDING) clr_mask = wdata[NSRC-1:0];
      if (do_claim) clr_mask = clr_mask | ack_mask;
   end

   // A new edge beats a same-cycle clear of the same bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         en       <= '0;
         timer_en <= 1'b0;
         claim    <= '0;
         busy     <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | rise;
         if (wr_en && off == OFF_ENABLE) begin
            en       <= wdata[NSRC-1:0];
            timer_en <= wdata[31];
         end
         if (do_claim) begin
            claim <= claim_id;
            busy  <= 1'b1;
         end else if (wr_en && off == OFF_CLAIM) begin
            claim <= '0;
            busy  <= 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         OFF_MTIME_LO: rdata = mtime[31:0];
         OFF_MTIME_HI: rdata = mtime[63:32];
         OFF_CMP_LO:   rdata = mtimecmp[31:0];
         OFF_CMP_HI:   rdata = mtimecmp[63:32];
         OFF_PENDING:  rdata[NSRC-1:0] = pending;
         OFF_ENABLE: begin
            rdata[NSRC-1:0] = en;
            rdata[31]       = timer_en;
         end
         OFF_CLAIM:    rdata[CW-1:0] = claim;
         OFF_STATUS:   rdata[1:0] = {timer_pend, busy};
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spo <= '0;
      end else if (rd_en) begin
         spo <= bswap(rdata);
      end
   end

endmodule

// File: doc/irq_timer_ctrl.md
# irq_timer_ctrl

Memory-mapped interrupt source block that drives the multicycle CPU's `eip`/`eip_istimer` inputs and consumes its `eip_reply` pulse. It provides a 64-bit machine timer (`mtime`/`mtimecmp`) and an edge-latched external-interrupt pending/enable/claim unit for up to 16 peripheral lines. It sits on the CPU data bus (`a`/`d`/`we`/`rd`/`spo`/`ready`) as a 1-wait-state slave behind the address decoder.

## Interface
- `BASE_ADDR`, 32'he0000000: base of the 32-byte register window; selected when `a[31:5] == BASE_ADDR[31:5]`.
- `NSRC`, 4: number of external sources, 1..16.
- `DIV`, 1: `mtime` increments once every `DIV` clocks; `DIV` ≥ 1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a`  in  32  bus address, word-aligned; `a[4:2]` selects the register.
- `d`  in  32  write data, bus byte order.
- `we`  in  1  write strobe, one cycle.
- `rd`  in  1  read strobe, one cycle.
- `spo`  out  32  read data, bus byte order.
- `ready`  out  1  transfer complete / slave idle.
- `src`  in  NSRC  asynchronous peripheral interrupt lines, active-high.
- `eip`  out  1  interrupt request to the CPU.
- `eip_istimer`  out  1  the current request is the timer.
- `eip_reply`  in  1  one-cycle acknowledge from the CPU.

## Operation
- Bus byte order: register bits [7:0] travel on bus bits [31:24], [15:8] on [23:16], and so on. Both `d` and `spo` are byte-swapped internally.
- Register map (offset, access):
  - 0x00 `mtime_lo` RW
  - 0x04 `mtime_hi` RW
  - 0x08 `mtimecmp_lo` RW
  - 0x0C `mtimecmp_hi` RW
  - 0x10 `pending` R/W1C, bits [NSRC-1:0]
  - 0x14 `enable` RW, bits [NSRC-1:0] plus bit 31 = timer enable
  - 0x18 `claim` R; any write = complete
  - 0x1C `status` R: bit0 `busy`, bit1 `timer_pend`
- Unused or unimplemented bits read 0; writes to them are ignored.
- Timer:
  - A prescale counter counts 0..DIV-1; on wrap, `mtime` increments by 1 as a full 64-bit value with carry from lo to hi.
  - A bus write to `mtime_lo`/`mtime_hi` overrides that cycle's increment for the written half. The other half still receives a carry if one occurs.
  - `timer_pend` = `enable[31]` & (`mtime` ≥ `mtimecmp`), unsigned 64-bit, combinational on the registers.
- External sources:
  - Each `src[i]` passes through a 2-FF synchroniser. A rising edge of the synchronised signal sets `pending[i]`.
  - A W1C write clears the written bits. If a set and a clear hit the same bit in the same cycle, set wins.
- Request outputs:
  - `ext_req` = |(`pending` & `enable[NSRC-1:0]`) & ~`busy`.
  - `eip` = `timer_pend` | `ext_req`.
  - `eip_istimer` = `timer_pend`. The timer has priority.
- Acknowledge:
  - On `eip_reply` with `eip_istimer` = 0: latch `claim` = (lowest set index of `pending & enable`) + 1, clear that pending bit, and set `busy`.
  - On `eip_reply` with `eip_istimer` = 1: no state change. Software clears the timer request by rewriting `mtimecmp` or `enable[31]`.
  - `eip_reply` while `eip` = 0 is ignored.
- Complete: any write to 0x18 clears `busy` and sets `claim` to 0.

## Timing
- Reset values: `mtime` 0, prescaler 0, `mtimecmp` 64'hFFFFFFFF_FFFFFFFF, `pending` 0, `enable` 0, `claim` 0, `busy` 0, synchronisers 0, `eip` 0, `eip_istimer` 0, `spo` 0, `ready` 1.
- Bus handshake:
  - `ready` is combinationally 0 in any cycle with a selected `rd` or `we`, and 1 otherwise.
  - A write takes effect at the end of the strobe cycle.
  - Read data is registered at the end of the strobe cycle. It is valid on `spo` from the next cycle, when `ready` = 1, and is held until the next selected read.
  - The CPU holds the address with strobes low while waiting; this is legal and needs no special handling.
- Unselected strobes leave `ready` = 1 and `spo` unchanged.
- A read of `mtime_lo` returns the pre-increment value of that cycle. There is no lo/hi snapshot; software uses the hi-lo-hi read sequence.
- `src` edge to `pending` set: 3 cycles (2 synchroniser stages plus edge register). `pending` to `eip`: combinational, so `eip` rises in the same cycle as `pending`.
- `eip_reply` and a W1C clear of the claimed bit in the same cycle: the claim still latches the id computed before the clear.
- Asynchronous reset mid-transfer returns everything to reset values immediately. `ready` = 1 on release.

## Test plan
- Reset with `DIV` = 1: all registers read back their reset values; `eip` = 0. Read of 0x08 returns `spo` = 32'hFFFFFFFF, with `ready` 0 in the strobe cycle and 1 in the next.
- Write `mtimecmp` = 10, `enable` = 32'h8000_0000: `eip` = `eip_istimer` = 1 exactly when `mtime` reaches 10. Writing `mtimecmp_lo` = 100 drops `eip` in the next cycle.
- Write `mtime_lo` = 32'hFFFFFFFF, `mtime_hi` = 0: after one tick, reads return lo = 0 and hi = 1. Same test with `DIV` = 4: the tick occurs 4 cycles later.
- Set `enable` = 4'b0110; pulse `src[2]` then `src[1]`: `eip` rises 3 cycles after the first edge. First `eip_reply` gives `claim` = 2 and `busy` = 1, with `eip` masked while `pending[2]` remains. Write 0x18: `busy` clears and `eip` reasserts. Second reply gives `claim` = 3.
- Write `pending` = 4'b1111 while `src[0]` rises in the same cycle: `pending[0]` stays 1; the other bits clear.
- Timer and external both pending: `eip_istimer` = 1 and the reply leaves `claim` = 0. After clearing the timer, `eip_istimer` = 0 and `eip` stays 1 for the external request.
